// File: rtl/slot_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : slot_tx_scheduler
// Description : Slot timer with periodic resync requests and a whole-frame
//               ctrl/data arbiter onto one 64-bit AXI-Stream MAC TX port.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_tx_scheduler #(
  parameter int P_SLOT_LEN   = 1000,
  parameter int P_GUARD      = 32,
  parameter int P_SLOT_NUM   = 8,
  parameter int P_SYN_PERIOD = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_slot_start,
  output logic [2:0]  o_cur_slot_id,
  output logic        o_slot_boundary,
  output logic        o_guard,
  output logic        o_syn_req,
  output logic        o_running,
  input  logic        s_ctrl_axis_tvalid,
  input  logic [63:0] s_ctrl_axis_tdata,
  input  logic        s_ctrl_axis_tlast,
  input  logic [7:0]  s_ctrl_axis_tkeep,
  input  logic        s_ctrl_axis_tuser,
  output logic        s_ctrl_axis_tready,
  input  logic        s_data_axis_tvalid,
  input  logic [63:0] s_data_axis_tdata,
  input  logic        s_data_axis_tlast,
  input  logic [7:0]  s_data_axis_tkeep,
  input  logic        s_data_axis_tuser,
  output logic        s_data_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready
);

  localparam int C_CNT_W = $clog2(P_SLOT_LEN + 1);
  localparam int C_SYN_W = $clog2(P_SYN_PERIOD + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST    = C_CNT_W'(P_SLOT_LEN - 1);
  localparam logic [C_CNT_W-1:0] C_GUARD_START = C_CNT_W'(P_SLOT_LEN - P_GUARD);
  localparam logic [2:0]         C_ID_LAST     = 3'(P_SLOT_NUM - 1);
  localparam logic [C_SYN_W-1:0] C_SYN_LAST    = C_SYN_W'(P_SYN_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  logic [C_CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]         slot_id_q, slot_id_d;
  logic [C_SYN_W-1:0] syn_cnt_q, syn_cnt_d;
  logic               running_q, running_d;
  logic               boundary_q, boundary_d;
  logic               syn_req_q, syn_req_d;
  state_t             state_q;

  always_comb begin
    slot_cnt_d = slot_cnt_q;
    slot_id_d  = slot_id_q;
    syn_cnt_d  = syn_cnt_q;
    running_d  = running_q;
    boundary_d = 1'b0;
    syn_req_d  = 1'b0;
    // A sync realignment wins over a coincident natural wrap.
    if (i_slot_start) begin
      slot_cnt_d = '0;
      slot_id_d  = '0;
      syn_cnt_d  = '0;
      running_d  = 1'b1;
      boundary_d = 1'b1;
    end else if (running_q) begin
      if (slot_cnt_q == C_CNT_LAST) begin
        slot_cnt_d = '0;
        boundary_d = 1'b1;
        if (slot_id_q == C_ID_LAST) begin
          slot_id_d = '0;
          if (syn_cnt_q == C_SYN_LAST) begin
            syn_cnt_d = '0;
            syn_req_d = 1'b1;
          end else begin
            syn_cnt_d = syn_cnt_q + C_SYN_W'(1);
          end
        end else begin
          slot_id_d = slot_id_q + 3'd1;
        end
      end else begin
        slot_cnt_d = slot_cnt_q + C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_cnt_q <= '0;
      slot_id_q  <= '0;
      syn_cnt_q  <= '0;
      running_q  <= 1'b0;
      boundary_q <= 1'b0;
      syn_req_q  <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      slot_id_q  <= slot_id_d;
      syn_cnt_q  <= syn_cnt_d;
      running_q  <= running_d;
      boundary_q <= boundary_d;
      syn_req_q  <= syn_req_d;
    end
  end

  assign o_cur_slot_id   = slot_id_q;
  assign o_slot_boundary = boundary_q;
  assign o_syn_req       = syn_req_q;
  assign o_running       = running_q;
  assign o_guard         = running_q && (slot_cnt_q >= C_GUARD_START);

  // Grants are frame-atomic: only tlast on an accepted beat releases the port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_ctrl_axis_tvalid) begin
            state_q <= ST_CTRL;
          end else if (s_data_axis_tvalid && running_q && !o_guard) begin
            state_q <= ST_DATA;
          end
        end
        ST_CTRL: begin
          if (s_ctrl_axis_tvalid && m_axis_tready && s_ctrl_axis_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (s_data_axis_tvalid && m_axis_tready && s_data_axis_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axis_tvalid      = 1'b0;
    m_axis_tdata       = '0;
    m_axis_tlast       = 1'b0;
    m_axis_tkeep       = '0;
    m_axis_tuser       = 1'b0;
    s_ctrl_axis_tready = 1'b0;
    s_data_axis_tready = 1'b0;
    case (state_q)
      ST_CTRL: begin
        m_axis_tvalid      = s_ctrl_axis_tvalid;
        m_axis_tdata       = s_ctrl_axis_tdata;
        m_axis_tlast       = s_ctrl_axis_tlast;
        m_axis_tkeep       = s_ctrl_axis_tkeep;
        m_axis_tuser       = s_ctrl_axis_tuser;
        s_ctrl_axis_tready = m_axis_tready;
      end
      ST_DATA: begin
        m_axis_tvalid      = s_data_axis_tvalid;
        m_axis_tdata       = s_data_axis_tdata;
        m_axis_tlast       = s_data_axis_tlast;
        m_axis_tkeep       = s_data_axis_tkeep;
        m_axis_tuser       = s_data_axis_tuser;
        s_data_axis_tready = m_axis_tready;
      end
      default: begin
        m_axis_tvalid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
